// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM keypad front end and its controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: key codes, front-end FSM state encoding, amount/counter widths,
//           and a small key classification helper.
package cajero_pkg;

  localparam int MONTO_W = 32;
  localparam int CNT_W   = 4;

  localparam logic [3:0] TECLA_BORRAR    = 4'hA;
  localparam logic [3:0] TECLA_RETROCESO = 4'hB;
  localparam logic [3:0] TECLA_ACEPTAR   = 4'hC;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    CONVERTIR = 2'd1,
    ENTREGAR  = 2'd2
  } estado_t;

  function automatic logic es_digito(input logic [3:0] t);
    return (t <= 4'd9);
  endfunction

endpackage

// File: rtl/entrada_teclado_if.sv
// Keypad-side and controller-side signal bundle of the keypad front end.
// Latency: n/a (wiring only).
// Backpressure: none; keys are strobes, outputs are one-cycle strobes.
// Ports: master = key source / consumer (drives card, mode, keys);
//        slave  = entrada_teclado (drives digit, amount, count, status).
interface entrada_teclado_if;
  import cajero_pkg::*;

  logic               tarjeta_recibida;
  logic               modo_monto;
  logic [3:0]         tecla;
  logic               tecla_stb;
  logic [3:0]         digito;
  logic               digito_stb;
  logic [MONTO_W-1:0] monto;
  logic               monto_stb;
  logic [CNT_W-1:0]   digitos_cnt;
  logic               ocupado;
  logic               tecla_invalida;

  modport master (
    output tarjeta_recibida, modo_monto, tecla, tecla_stb,
    input  digito, digito_stb, monto, monto_stb, digitos_cnt, ocupado,
           tecla_invalida
  );

  modport slave (
    input  tarjeta_recibida, modo_monto, tecla, tecla_stb,
    output digito, digito_stb, monto, monto_stb, digitos_cnt, ocupado,
           tecla_invalida
  );

endinterface

// File: rtl/bcd_a_binario.sv
// Iterative BCD to binary converter: one x10+digit step per cycle, oldest digit first.
// Latency: start edge loads, then cnt step edges; done is high during the last step.
// Backpressure: none; start reloads unconditionally, abort stops it.
// Ports: start/abort control, cnt = digits to convert, buffer = BCD digits
//        (index 0 newest); done = last step this cycle, resultado = accumulator.
module bcd_a_binario
  import cajero_pkg::*;
#(
  parameter int MAX_DIGITOS = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            cnt,
  input  logic [MAX_DIGITOS-1:0][3:0] buffer,
  output logic                        done,
  output logic [MONTO_W-1:0]          resultado
);

  // Digits are captured at start so that the caller may clear its own
  // buffer (e.g. on a mode change) without corrupting a running conversion.
  logic [MAX_DIGITOS-1:0][3:0] bcd;
  logic [CNT_W-1:0]            idx;
  logic                        activo;
  logic [MONTO_W-1:0]          acc;
  logic [MONTO_W-1:0]          paso;
  logic [3:0]                  dig_sel;

  // Mux written as a compare loop so idx values beyond the buffer read 0.
  always_comb begin
    dig_sel = 4'd0;
    for (int i = 0; i < MAX_DIGITOS; i++) begin
      if (idx == CNT_W'(i)) dig_sel = bcd[i];
    end
  end

  assign paso      = (acc << 3) + (acc << 1) + MONTO_W'(dig_sel);
  assign done      = activo && (idx == '0);
  assign resultado = acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd    <= '0;
      idx    <= '0;
      acc    <= '0;
      activo <= 1'b0;
    end else if (abort) begin
      activo <= 1'b0;
    end else if (start) begin
      bcd    <= buffer;
      idx    <= cnt - CNT_W'(1);
      acc    <= '0;
      activo <= 1'b1;
    end else if (activo) begin
      acc <= paso;
      if (idx == '0) activo <= 1'b0;
      else           idx    <= idx - CNT_W'(1);
    end
  end

endmodule

// File: rtl/entrada_teclado.sv
// Keypad front end: PIN digit strobes, BCD amount buffer, and amount conversion to binary.
// Latency: key responses 1 cycle after the strobe; amount strobe cnt+1 cycles after aceptar.
// Backpressure: none; keys arriving while busy are dropped and flagged as invalid.
// Ports: clk, rst (async, active-low), io (entrada_teclado_if.slave): card/mode/key
//        inputs; digit, amount, digit count, busy and invalid-key outputs.
module entrada_teclado
  import cajero_pkg::*;
#(
  parameter int MAX_DIGITOS = 9  // 2..9 so that 10^N-1 fits in 32 bits
) (
  input  logic                    clk,
  input  logic                    rst,
  entrada_teclado_if.slave        io
);

  estado_t                     estado, estado_n;
  logic                        modo_q;
  logic                        cambio_modo;
  logic [MAX_DIGITOS-1:0][3:0] buffer, buffer_n, buf_eff;
  logic [CNT_W-1:0]            cnt_q, cnt_n, cnt_eff;
  logic [3:0]                  digito_q, digito_n;
  logic                        digito_stb_q, digito_stb_n;
  logic [MONTO_W-1:0]          monto_q, monto_n;
  logic                        monto_stb_q, monto_stb_n;
  logic                        ocupado_q, ocupado_n;
  logic                        invalida_q, invalida_n;
  logic                        conv_start, conv_abort, conv_done;
  logic [MONTO_W-1:0]          conv_res;

  bcd_a_binario #(.MAX_DIGITOS(MAX_DIGITOS)) u_conv (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .abort     (conv_abort),
    .cnt       (cnt_eff),
    .buffer    (buf_eff),
    .done      (conv_done),
    .resultado (conv_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) estado <= ESPERA;
    else      estado <= estado_n;
  end

  always_comb begin
    // A mode change empties the buffer in the same cycle, so a key sampled
    // together with the change already sees the empty buffer.
    cambio_modo  = (io.modo_monto != modo_q);
    buf_eff      = cambio_modo ? '0 : buffer;
    cnt_eff      = cambio_modo ? '0 : cnt_q;
    estado_n     = estado;
    buffer_n     = buf_eff;
    cnt_n        = cnt_eff;
    digito_n     = digito_q;
    digito_stb_n = 1'b0;
    monto_n      = monto_q;
    monto_stb_n  = 1'b0;
    invalida_n   = 1'b0;
    conv_start   = 1'b0;
    conv_abort   = 1'b0;

    if (!io.tarjeta_recibida) begin
      // Card removal wins over everything, including a key in the same cycle.
      estado_n   = ESPERA;
      buffer_n   = '0;
      cnt_n      = '0;
      conv_abort = 1'b1;
    end else begin
      unique case (estado)
        ESPERA: begin
          if (io.tecla_stb) begin
            if (!io.modo_monto) begin
              if (es_digito(io.tecla)) begin
                digito_n     = io.tecla;
                digito_stb_n = 1'b1;
              end else begin
                invalida_n = 1'b1;
              end
            end else if (es_digito(io.tecla)) begin
              if (cnt_eff < CNT_W'(MAX_DIGITOS)) begin
                buffer_n = {buf_eff[MAX_DIGITOS-2:0], io.tecla};
                cnt_n    = cnt_eff + CNT_W'(1);
              end else begin
                invalida_n = 1'b1;
              end
            end else begin
              case (io.tecla)
                TECLA_BORRAR: begin
                  buffer_n = '0;
                  cnt_n    = '0;
                end
                TECLA_RETROCESO: begin
                  if (cnt_eff == '0) begin
                    invalida_n = 1'b1;
                  end else begin
                    buffer_n = {4'h0, buf_eff[MAX_DIGITOS-1:1]};
                    cnt_n    = cnt_eff - CNT_W'(1);
                  end
                end
                TECLA_ACEPTAR: begin
                  if (cnt_eff == '0) begin
                    invalida_n = 1'b1;
                  end else begin
                    conv_start = 1'b1;
                    estado_n   = CONVERTIR;
                  end
                end
                default: invalida_n = 1'b1;
              endcase
            end
          end
        end
        CONVERTIR: begin
          invalida_n = io.tecla_stb;
          if (conv_done) begin
            buffer_n = '0;
            cnt_n    = '0;
            estado_n = ENTREGAR;
          end
        end
        ENTREGAR: begin
          // monto is loaded here, not at the last step, so a card removal
          // during the final step leaves the previous amount untouched.
          invalida_n  = io.tecla_stb;
          monto_n     = conv_res;
          monto_stb_n = 1'b1;
          estado_n    = ESPERA;
        end
        default: estado_n = ESPERA;
      endcase
    end

    ocupado_n = (estado_n != ESPERA);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      modo_q       <= 1'b0;
      buffer       <= '0;
      cnt_q        <= '0;
      digito_q     <= '0;
      digito_stb_q <= 1'b0;
      monto_q      <= '0;
      monto_stb_q  <= 1'b0;
      ocupado_q    <= 1'b0;
      invalida_q   <= 1'b0;
    end else begin
      modo_q       <= io.modo_monto;
      buffer       <= buffer_n;
      cnt_q        <= cnt_n;
      digito_q     <= digito_n;
      digito_stb_q <= digito_stb_n;
      monto_q      <= monto_n;
      monto_stb_q  <= monto_stb_n;
      ocupado_q    <= ocupado_n;
      invalida_q   <= invalida_n;
    end
  end

  assign io.digito         = digito_q;
  assign io.digito_stb     = digito_stb_q;
  assign io.monto          = monto_q;
  assign io.monto_stb      = monto_stb_q;
  assign io.digitos_cnt    = cnt_q;
  assign io.ocupado        = ocupado_q;
  assign io.tecla_invalida = invalida_q;

endmodule

// File: tb/tb_entrada_teclado.sv
// Bench for entrada_teclado: directed scenarios plus random keystrokes against a digit-list model.
// Expected strobes (value, cycle) are queued at stimulus time; a negedge monitor pops and compares.
// Ports: drives the master side of entrada_teclado_if; clk/rst generated here.
module tb_entrada_teclado;
  import cajero_pkg::*;

  localparam int MAXD = 9;

  typedef struct {
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  entrada_teclado_if bus ();

  entrada_teclado #(.MAX_DIGITOS(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  ev_t    exp_dig[$];
  ev_t    exp_mon[$];
  int     exp_inv[$];
  int     model_q[$];          // buffered amount digits, oldest first
  int     busy_lo = -10;       // cycles during which ocupado must read 1
  int     busy_hi = -10;
  longint last_monto = 0;
  string  req_nm[$];
  longint req_act[$];
  longint req_exp[$];
  int     pin [4] = '{6, 9, 5, 3};
  int     r, s, k;
  ev_t    e;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  task automatic compare(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (req_nm.size() > 0)
      compare(req_nm.pop_front(), req_act.pop_front(), req_exp.pop_front());
    if (!rst) begin
      last_monto = 0;
    end else begin
      if (exp_dig.size() > 0 && exp_dig[0].cyc < cyc) begin
        compare("digito_stb missing", 0, 1);
        void'(exp_dig.pop_front());
      end
      if (exp_mon.size() > 0 && exp_mon[0].cyc < cyc) begin
        compare("monto_stb missing", 0, 1);
        void'(exp_mon.pop_front());
      end
      if (exp_inv.size() > 0 && exp_inv[0] < cyc) begin
        compare("tecla_invalida missing", 0, 1);
        void'(exp_inv.pop_front());
      end
      if (bus.digito_stb) begin
        if (exp_dig.size() == 0) compare("digito_stb unexpected", 1, 0);
        else begin
          e = exp_dig.pop_front();
          compare("digito_stb cycle", cyc, e.cyc);
          compare("digito value", bus.digito, e.val);
        end
      end
      if (bus.monto_stb) begin
        if (exp_mon.size() == 0) compare("monto_stb unexpected", 1, 0);
        else begin
          e = exp_mon.pop_front();
          compare("monto_stb cycle", cyc, e.cyc);
          compare("monto value", bus.monto, e.val);
          last_monto = e.val;
        end
      end
      if (bus.tecla_invalida) begin
        if (exp_inv.size() == 0) compare("tecla_invalida unexpected", 1, 0);
        else compare("tecla_invalida cycle", cyc, exp_inv.pop_front());
      end
      compare("ocupado", bus.ocupado, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    end
  end

  // ---------------- reference model ----------------
  task automatic post(input string nm, input longint act, input longint req);
    req_nm.push_back(nm);
    req_act.push_back(act);
    req_exp.push_back(req);
  endtask

  // Key sampled at edge ed; responses become visible in cycle ed.
  task automatic model_key(input int key, input int ed);
    longint v;
    int n;
    if (ed - 1 >= busy_lo && ed - 1 <= busy_hi) exp_inv.push_back(ed);
    else if (!bus.modo_monto) begin
      if (key <= 9) exp_dig.push_back('{key, ed});
      else          exp_inv.push_back(ed);
    end else if (key <= 9) begin
      if (model_q.size() < MAXD) model_q.push_back(key);
      else                       exp_inv.push_back(ed);
    end else if (key == 10) begin
      model_q.delete();
    end else if (key == 11) begin
      if (model_q.size() == 0) exp_inv.push_back(ed);
      else void'(model_q.pop_back());
    end else if (key == 12) begin
      if (model_q.size() == 0) exp_inv.push_back(ed);
      else begin
        v = 0;
        foreach (model_q[i]) v = v * 10 + model_q[i];
        n = model_q.size();
        exp_mon.push_back('{int'(v), ed + n + 1});
        busy_lo = ed;
        busy_hi = ed + n;
        model_q.delete();
      end
    end else begin
      exp_inv.push_back(ed);
    end
  endtask

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_key(input int key);
    model_key(key, cyc + 1);
    bus.tecla     = 4'(key);
    bus.tecla_stb = 1'b1;
    @(posedge clk);
    #1;
    bus.tecla_stb = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    if (m != bus.modo_monto) model_q.delete();
    bus.modo_monto = m;
    idle(1);
  endtask

  task automatic drop_card(input int n, input bit with_key);
    int ed;
    ed = cyc + 1;
    model_q.delete();
    if (exp_mon.size() > 0 && exp_mon[$].cyc >= ed) void'(exp_mon.pop_back());
    if (busy_hi >= ed) busy_hi = ed - 1;
    bus.tarjeta_recibida = 1'b0;
    if (with_key) begin
      bus.tecla     = 4'd9;
      bus.tecla_stb = 1'b1;
    end
    idle(1);
    bus.tecla_stb = 1'b0;
    idle(n - 1);
    bus.tarjeta_recibida = 1'b1;
  endtask

  task automatic chk_cnt(input string nm);
    post(nm, bus.digitos_cnt, model_q.size());
  endtask

  task automatic chk_zero(input string tag);
    post({tag, " digito"}, bus.digito, 0);
    post({tag, " digito_stb"}, bus.digito_stb, 0);
    post({tag, " monto"}, bus.monto, 0);
    post({tag, " monto_stb"}, bus.monto_stb, 0);
    post({tag, " digitos_cnt"}, bus.digitos_cnt, 0);
    post({tag, " ocupado"}, bus.ocupado, 0);
    post({tag, " tecla_invalida"}, bus.tecla_invalida, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.tarjeta_recibida = 1'b1;
    bus.modo_monto       = 1'b0;
    bus.tecla            = 4'd0;
    bus.tecla_stb        = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    idle(2);

    // PIN digits, widely spaced
    for (int i = 0; i < 4; i++) begin
      send_key(pin[i]);
      idle(19);
    end

    // 30000
    set_mode(1'b1);
    idle(1);
    send_key(3);
    for (int i = 0; i < 4; i++) send_key(0);
    send_key(12);
    idle(8);
    chk_cnt("cnt after 30000");

    // 4,5,2,9, retroceso, 0 -> 4520
    send_key(4); chk_cnt("cnt seq 1");
    send_key(5); chk_cnt("cnt seq 2");
    send_key(2); chk_cnt("cnt seq 3");
    send_key(9); chk_cnt("cnt seq 4");
    send_key(11); chk_cnt("cnt seq 3 after retroceso");
    send_key(0); chk_cnt("cnt seq 4 again");
    send_key(12);
    idle(7);
    post("cnt after 4520", bus.digitos_cnt, 0);

    // ten nines: last one rejected, 999999999
    for (int i = 0; i < 10; i++) send_key(9);
    post("cnt full", bus.digitos_cnt, MAXD);
    send_key(12);
    idle(12);

    // empty aceptar, then card removed mid-conversion (key in same cycle dropped)
    send_key(12);
    idle(2);
    send_key(9);
    for (int i = 0; i < 4; i++) send_key(0);
    send_key(12);
    idle(1);
    drop_card(2, 1'b1);
    idle(8);
    post("monto held after card drop", bus.monto, last_monto);
    post("cnt after card drop", bus.digitos_cnt, 0);

    // key while busy, then async reset mid-conversion
    send_key(1);
    send_key(2);
    send_key(3);
    send_key(12);
    send_key(5);
    idle(1);
    rst = 1'b0;
    #1;
    chk_zero("async reset");
    exp_dig.delete();
    exp_mon.delete();
    exp_inv.delete();
    model_q.delete();
    busy_lo = -10;
    busy_hi = -10;
    idle(2);
    rst = 1'b1;
    idle(2);
    send_key(7);
    chk_cnt("cnt after reset key");

    // random traffic
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) set_mode(~bus.modo_monto);
      else if (r < 7) drop_card($urandom_range(1, 2), 1'b0);
      else begin
        s = $urandom_range(0, 99);
        if (s < 65)      k = $urandom_range(0, 9);
        else if (s < 75) k = 12;
        else if (s < 83) k = 11;
        else if (s < 86) k = 10;
        else             k = $urandom_range(13, 15);
        send_key(k);
        idle($urandom_range(0, 2));
      end
    end

    idle(15);
    post("pending digito events", exp_dig.size(), 0);
    post("pending monto events", exp_mon.size(), 0);
    post("pending invalid events", exp_inv.size(), 0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/entrada_teclado.md
# entrada_teclado

- Keypad front end that sits directly upstream of the ATM controller (`cajero`).
- Turns raw keystrokes into the controller's PIN digit strobes, and into a validated 32-bit deposit/withdrawal amount with a one-cycle strobe.
- Amount digits are buffered as BCD and converted to binary by a multi-cycle sequencer when the accept key is pressed.

## Interface
Parameters:
- MAX_DIGITOS, 9, maximum amount digits buffered; must be ≤ 9 so that 10^N−1 fits in 32 bits.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- tarjeta_recibida  input  1  card present; low clears the buffer and aborts any conversion.
- modo_monto  input  1  0 = PIN entry, 1 = amount entry.
- tecla  input  4  key code: 0–9 digit, 0xA borrar, 0xB retroceso, 0xC aceptar, 0xD–0xF unused.
- tecla_stb  input  1  one-cycle key-valid strobe.
- digito  output  4  PIN digit to controller.
- digito_stb  output  1  one-cycle PIN digit strobe.
- monto  output  32  converted amount, binary; holds until the next conversion.
- monto_stb  output  1  one-cycle amount-valid strobe.
- digitos_cnt  output  4  digits currently buffered, for the display.
- ocupado  output  1  high while a conversion is in progress.
- tecla_invalida  output  1  one-cycle pulse when a keystroke is rejected.

## Operation
- Reset (rst=0): all outputs 0, buffer cleared, state ESPERA.
- **States:**
  - ESPERA: accepts keys.
  - CONVERTIR: iterative BCD→binary conversion.
  - ENTREGAR: drives monto_stb, then returns to ESPERA.
- **PIN mode (modo_monto=0), ESPERA:**
  - A digit key (0–9) → digito=tecla, digito_stb=1 for one cycle.
  - Any other key → tecla_invalida pulse.
  - Buffer untouched.
- **Amount mode (modo_monto=1), ESPERA:**
  - Digit key with digitos_cnt < MAX_DIGITOS: shift into BCD buffer (newest at index 0), cnt+1.
  - Digit key with cnt = MAX_DIGITOS: ignored, tecla_invalida.
  - borrar: cnt=0, buffer zeroed.
  - retroceso: shift buffer right one digit, cnt−1. With cnt=0: tecla_invalida.
  - aceptar with cnt>0: acc=0, idx=cnt−1, go to CONVERTIR.
  - aceptar with cnt=0: tecla_invalida.
  - Unused codes: tecla_invalida.
- **CONVERTIR:**
  - Each cycle: acc = (acc<<3)+(acc<<1)+buf[idx], in 32-bit unsigned arithmetic.
  - When idx=0: monto←acc, buffer cleared, cnt=0, go to ENTREGAR.
  - Otherwise idx−1.
- **ENTREGAR:** monto_stb=1 for exactly one cycle, then ESPERA.
- ocupado=1 in CONVERTIR and ENTREGAR.
- A tecla_stb seen while ocupado → key dropped, tecla_invalida.
- **tarjeta_recibida=0 (any state):**
  - Next cycle: buffer cleared, cnt=0, state ESPERA.
  - No monto_stb; monto keeps its old value.
  - Keys arriving while it is low are dropped silently, with no tecla_invalida.
- **Mode change:**
  - Any change of modo_monto (registered edge detect) clears the buffer.
  - A conversion already in progress completes.
- Leading zeros are accepted and count toward MAX_DIGITOS.

## Timing
- All outputs registered.
- digito_stb / tecla_invalida: asserted the cycle after the sampled tecla_stb.
- Amount latency: aceptar sampled at edge T.
  - CONVERTIR occupies edges T+1 … T+cnt.
  - monto valid and monto_stb high after edge T+cnt+1, for one cycle.
- Back-to-back keystrokes (tecla_stb high on consecutive cycles) are supported in ESPERA; each one is processed.
- tarjeta_recibida and tecla_stb in the same cycle: clear wins, the key is dropped.
- Asynchronous reset mid-conversion: immediate return to reset values, no strobe.

## Structure
- Shared package `cajero_pkg` holds:
  - Key codes: TECLA_BORRAR=4'hA, TECLA_RETROCESO=4'hB, TECLA_ACEPTAR=4'hC.
  - State encoding: ESPERA, CONVERTIR, ENTREGAR.
  - MONTO_W=32.
- One sub-module, `bcd_a_binario`:
  - Holds the acc/idx datapath and the ×10+digit step.
  - Interface: start, cnt, buffer in; done, resultado out.
- `entrada_teclado` owns the key decode, buffer, FSM and output registers.

## Test plan
- PIN mode, keys 6,9,5,3 at 20-cycle spacing → four digito_stb pulses carrying 6,9,5,3; monto_stb never asserted.
- Amount mode, keys 3,0,0,0,0, aceptar → ocupado for 6 cycles; monto=30000; single monto_stb 6 cycles after aceptar.
- Amount mode, keys 4,5,2,9, retroceso, 0, aceptar → monto=4520; digitos_cnt sequence 1,2,3,4,3,4,0.
- Amount mode, ten digit keys of 9 then aceptar → tenth key gives tecla_invalida; monto=999999999.
- Amount mode, aceptar with empty buffer → tecla_invalida; no monto_stb. Then keys 9,0,0,0,0, aceptar, with tarjeta_recibida dropped 2 cycles into CONVERTIR → no monto_stb; monto unchanged; cnt=0.
- Keystroke during ocupado, plus a reset asserted mid-conversion → tecla_invalida for the keystroke; after reset all outputs 0 and state ESPERA.
